core_lsu: RTL and testbench

Load/store unit for the RV32I core; the consumer end of the decode stage's load/store control fields (is_load_store, mem_w, LIS_op, reg_addr).
Takes the effective address from the ALU (rs1 + imm) and the store data (rs2).
Drives a valid/grant/rvalid data-memory port with byte enables, then returns sign- or zero-extended load data with a register write-back strobe.
Stalls the core through busy_o while an access is in flight.

---
 rtl/core_lsu_pkg.sv | 52 +++++
 rtl/core_lsu_align.sv | 82 ++++++++
 rtl/core_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_core_lsu.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: LIS op codes, widths,
// FSM state encoding and small op-decoding helpers.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN (adds REQ2/WAIT2 states).
package core_lsu_pkg;

    localparam int LIS_OP_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int LSU_BE_WIDTH   = 4;

    localparam logic [LIS_OP_WIDTH-1:0] LIS_LB  = 4'd0;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LH  = 4'd1;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LW  = 4'd2;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LBU = 4'd3;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_LHU = 4'd4;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SB  = 4'd5;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SH  = 4'd6;
    localparam logic [LIS_OP_WIDTH-1:0] LIS_SW  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3
`ifdef LSU_MISALIGNED_SPLIT_EN
        ,
        S_REQ2  = 3'd4,
        S_WAIT2 = 3'd5
`endif
    } lsu_state_e;

    function automatic logic lis_is_store(input logic [LIS_OP_WIDTH-1:0] op);
        return (op == LIS_SB) || (op == LIS_SH) || (op == LIS_SW);
    endfunction

    // An op code is only meaningful together with the direction decode gave it.
    function automatic logic lis_legal(input logic [LIS_OP_WIDTH-1:0] op, input logic we);
        if (we)
            return lis_is_store(op);
        return (op == LIS_LB) || (op == LIS_LH) || (op == LIS_LW) ||
               (op == LIS_LBU) || (op == LIS_LHU);
    endfunction

    // Access size in bytes; illegal codes fall into the word bucket.
    function automatic logic [2:0] lis_size(input logic [LIS_OP_WIDTH-1:0] op);
        case (op)
            LIS_LB, LIS_LBU, LIS_SB: return 3'd1;
            LIS_LH, LIS_LHU, LIS_SH: return 3'd2;
            default:                 return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane logic for the load/store unit: byte enables and store
// lane data from op + offset, and extraction/extension of returned load data.
// Macro LSU_MISALIGNED_SPLIT_EN: enables shifted enables across two words and
// merging of two read words before extension.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [LIS_OP_WIDTH-1:0] op_i,
    input  logic [1:0]              off_i,
    input  logic [31:0]             wdata_i,
    input  logic [LIS_OP_WIDTH-1:0] ld_op_i,
    input  logic [1:0]              ld_off_i,
    input  logic [31:0]             rdata_lo_i,
`ifdef LSU_MISALIGNED_SPLIT_EN
    input  logic [31:0]             rdata_hi_i,
    output logic [3:0]              be_hi_o,
    output logic [31:0]             wdata_hi_o,
    output logic                    split_o,
`endif
    output logic [3:0]              be_lo_o,
    output logic [31:0]             wdata_lo_o,
    output logic                    misaligned_o,
    output logic [31:0]             load_data_o
);

    logic [2:0]  size_w;
    logic [31:0] shifted_w;

    assign size_w = lis_size(op_i);

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [3:0]  mask_w;
    logic [7:0]  be_wide_w;
    logic [63:0] wd_wide_w;

    // Contiguous enable mask shifted across a two-word window; upper half is the second word.
    always_comb begin
        mask_w       = (size_w == 3'd1) ? 4'b0001 : (size_w == 3'd2) ? 4'b0011 : 4'b1111;
        be_wide_w    = 8'(mask_w) << off_i;
        wd_wide_w    = {32'b0, wdata_i} << {off_i, 3'b000};
        be_lo_o      = be_wide_w[3:0];
        be_hi_o      = be_wide_w[7:4];
        wdata_lo_o   = wd_wide_w[31:0];
        wdata_hi_o   = wd_wide_w[63:32];
        split_o      = |be_wide_w[7:4];
        misaligned_o = 1'b0;
        shifted_w    = 32'({rdata_hi_i, rdata_lo_i} >> {ld_off_i, 3'b000});
    end
`else
    // Naturally aligned lanes only; store data is replicated so any lane can pick it up.
    always_comb begin
        case (size_w)
            3'd1: begin
                be_lo_o    = 4'b0001 << off_i;
                wdata_lo_o = {4{wdata_i[7:0]}};
            end
            3'd2: begin
                be_lo_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_lo_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_lo_o    = 4'b1111;
                wdata_lo_o = wdata_i;
            end
        endcase
        misaligned_o = ((size_w == 3'd2) && off_i[0]) || ((size_w == 3'd4) && (off_i != 2'b00));
        shifted_w    = rdata_lo_i >> {ld_off_i, 3'b000};
    end
`endif

    // Sign- or zero-extend the addressed lane down at bit 0.
    always_comb begin
        case (ld_op_i)
            LIS_LB:  load_data_o = {{24{shifted_w[7]}}, shifted_w[7:0]};
            LIS_LBU: load_data_o = {24'b0, shifted_w[7:0]};
            LIS_LH:  load_data_o = {{16{shifted_w[15]}}, shifted_w[15:0]};
            LIS_LHU: load_data_o = {16'b0, shifted_w[15:0]};
            default: load_data_o = shifted_w;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// RV32I load/store unit: accepts one load/store from decode, drives a
// valid/grant/rvalid data-memory port and returns extended load data with a
// register write-back strobe. busy_o stalls the core while an access is open.
// Macro LSU_MISALIGNED_SPLIT_EN: misaligned accesses are split into two word
// transactions (REQ2/WAIT2) instead of completing with err_o.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [LIS_OP_WIDTH-1:0]   lis_op_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [LSU_BE_WIDTH-1:0]   dmem_be_o,
    output logic [ADDR_W-1:0]         dmem_addr_o,
    output logic [DATA_W-1:0]         dmem_wdata_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_W-1:0]         dmem_rdata_i
);

    lsu_state_e                state_q;
    logic [LIS_OP_WIDTH-1:0]   op_q;
    logic                      we_q;
    logic [1:0]                off_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      done_q, err_q, reg_we_q;
    logic [DATA_W-1:0]         rdata_q;
    logic                      dmem_req_q, dmem_we_q;
    logic [LSU_BE_WIDTH-1:0]   dmem_be_q;
    logic [ADDR_W-1:0]         dmem_addr_q;
    logic [DATA_W-1:0]         dmem_wdata_q;

    logic [3:0]                be_lo_w;
    logic [31:0]               wdata_lo_w, ld_data_w, rd_lo_w;
    logic                      mis_w, bad_w;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [3:0]                be_hi_w, be_hi_q;
    logic [31:0]               wdata_hi_w, wdata_hi_q, rlo_q;
    logic                      split_w, split_q;

    assign rd_lo_w = split_q ? rlo_q : dmem_rdata_i;
`else
    assign rd_lo_w = dmem_rdata_i;
`endif

    core_lsu_align u_align (
        .op_i         (lis_op_i),
        .off_i        (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .ld_op_i      (op_q),
        .ld_off_i     (off_q),
        .rdata_lo_i   (rd_lo_w),
`ifdef LSU_MISALIGNED_SPLIT_EN
        .rdata_hi_i   (dmem_rdata_i),
        .be_hi_o      (be_hi_w),
        .wdata_hi_o   (wdata_hi_w),
        .split_o      (split_w),
`endif
        .be_lo_o      (be_lo_w),
        .wdata_lo_o   (wdata_lo_w),
        .misaligned_o (mis_w),
        .load_data_o  (ld_data_w)
    );

    assign bad_w = !lis_legal(lis_op_i, we_i) || mis_w;

    // Busy covers the acceptance cycle combinationally, then every non-idle state.
    assign busy_o       = (state_q != S_IDLE) || req_i;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign reg_we_o     = reg_we_q;
    assign rd_addr_o    = rd_q;
    assign rdata_o      = rdata_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;

    // Access FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            we_q         <= 1'b0;
            off_q        <= 2'b00;
            rd_q         <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            reg_we_q     <= 1'b0;
            rdata_q      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            be_hi_q      <= '0;
            wdata_hi_q   <= '0;
            rlo_q        <= '0;
            split_q      <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            reg_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        op_q  <= lis_op_i;
                        we_q  <= we_i;
                        off_q <= addr_i[1:0];
                        rd_q  <= rd_addr_i;
                        if (bad_w) begin
                            // Rejected accesses never touch memory.
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q      <= S_REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= we_i;
                            dmem_be_q    <= be_lo_w;
                            dmem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                            dmem_wdata_q <= wdata_lo_w;
`ifdef LSU_MISALIGNED_SPLIT_EN
                            be_hi_q      <= be_hi_w;
                            wdata_hi_q   <= wdata_hi_w;
                            split_q      <= split_w;
`endif
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (split_q) begin
                            rlo_q        <= dmem_rdata_i;
                            state_q      <= S_REQ2;
                            dmem_req_q   <= 1'b1;
                            dmem_be_q    <= be_hi_q;
                            dmem_addr_q  <= dmem_addr_q + ADDR_W'(4);
                            dmem_wdata_q <= wdata_hi_q;
                        end else begin
                            state_q  <= S_RESP;
                            done_q   <= 1'b1;
                            reg_we_q <= !we_q;
                            rdata_q  <= ld_data_w;
                        end
`else
                        state_q  <= S_RESP;
                        done_q   <= 1'b1;
                        reg_we_q <= !we_q;
                        rdata_q  <= ld_data_w;
`endif
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                S_REQ2: begin
                    if (dmem_gnt_i) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= S_WAIT2;
                    end
                end
                S_WAIT2: begin
                    if (dmem_rvalid_i) begin
                        state_q  <= S_RESP;
                        done_q   <= 1'b1;
                        reg_we_q <= !we_q;
                        rdata_q  <= ld_data_w;
                    end
                end
`endif
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: byte-addressed reference memory model,
// directed scenarios followed by randomized loads/stores.
module tb_core_lsu;
    import core_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [3:0]  lis_op_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        busy_o, done_o, err_o, reg_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    always #5 clk = ~clk;

    core_lsu dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .lis_op_i(lis_op_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .reg_we_o(reg_we_o),
        .rd_addr_o(rd_addr_o), .rdata_o(rdata_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  bus_mem [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] last_rdata, last_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus_word(input logic [31:0] wa);
        int b;
        b = int'(wa[9:0]);
        return {bus_mem[(b+3)%1024], bus_mem[(b+2)%1024], bus_mem[(b+1)%1024], bus_mem[b]};
    endfunction

    function automatic int op_bytes(input logic [3:0] op);
        if (op == LIS_LB || op == LIS_LBU || op == LIS_SB) return 1;
        if (op == LIS_LH || op == LIS_LHU || op == LIS_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_ok(input logic [3:0] op, input logic we);
        if (we) return (op == LIS_SB || op == LIS_SH || op == LIS_SW);
        return (op == LIS_LB || op == LIS_LH || op == LIS_LW || op == LIS_LBU || op == LIS_LHU);
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            bus_mem[(int'(a[9:0]) + k) % 1024] = w[8*k +: 8];
            ref_mem[(int'(a[9:0]) + k) % 1024] = w[8*k +: 8];
        end
    endtask

    // One complete access: drives the request, plays the memory side with the
    // given grant/response delays and checks everything against the byte model.
    task automatic do_access(input logic [3:0] op, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rdl);
        int          size, n_exp, n_got, exp_cyc, c_done, gcnt, rv_cnt;
        bit          err, in_req;
        logic [31:0] exp_wa [2];
        logic [3:0]  exp_be [2];
        logic [7:0]  exp_lane [2][4];
        logic [31:0] exp_ld, ba, wa, rv_wa, s_addr, s_wd;
        logic [3:0]  s_be;
        logic        s_we;

        size = op_bytes(op);
        err  = !op_ok(op, we);
`ifndef LSU_MISALIGNED_SPLIT_EN
        if ((int'(a[1:0]) % size) != 0) err = 1'b1;
`endif
        n_exp = 0;
        exp_ld = '0;
        for (int k = 0; k < size; k++) begin
            ba = a + 32'(k);
            exp_ld |= 32'(ref_mem[int'(ba[9:0])]) << (8*k);
            if (!err) begin
                wa = {ba[31:2], 2'b00};
                if (n_exp == 0 || exp_wa[n_exp-1] != wa) begin
                    n_exp++;
                    exp_wa[n_exp-1] = wa;
                    exp_be[n_exp-1] = 4'b0000;
                end
                exp_be[n_exp-1][ba[1:0]]   = 1'b1;
                exp_lane[n_exp-1][ba[1:0]] = wd[8*k +: 8];
            end
        end
        if (op == LIS_LB && exp_ld[7])  exp_ld |= 32'hFFFF_FF00;
        if (op == LIS_LH && exp_ld[15]) exp_ld |= 32'hFFFF_0000;
        exp_cyc = err ? 1 : 1 + n_exp * (gd + rdl + 2);

        @(negedge clk);
        lis_op_i = op; we_i = we; addr_i = a; wdata_i = wd; rd_addr_i = rd; req_i = 1'b1;
        #1 chk("busy_accept", 32'(busy_o), 32'd1);

        n_got = 0; in_req = 1'b0; gcnt = 0; rv_cnt = -1; c_done = 0;
        rv_wa = '0; s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
            if (done_o) begin
                c_done = c;
                break;
            end
            chk("busy_held", 32'(busy_o), 32'd1);
            if (rv_cnt >= 0) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = bus_word(rv_wa);
                end
                rv_cnt--;
            end
            if (dmem_req_o) begin
                if (!in_req) begin
                    in_req = 1'b1; gcnt = gd;
                    s_addr = dmem_addr_o; s_be = dmem_be_o; s_we = dmem_we_o; s_wd = dmem_wdata_o;
                end else begin
                    chk("stable_addr", dmem_addr_o, s_addr);
                    chk("stable_be", 32'(dmem_be_o), 32'(s_be));
                    chk("stable_we", 32'(dmem_we_o), 32'(s_we));
                    chk("stable_wdata", dmem_wdata_o, s_wd);
                end
                if (gcnt == 0) begin
                    dmem_gnt_i = 1'b1;
                    in_req = 1'b0;
                    if (n_got < n_exp) begin
                        chk("req_addr", dmem_addr_o, exp_wa[n_got]);
                        chk("req_be", 32'(dmem_be_o), 32'(exp_be[n_got]));
                        chk("req_we", 32'(dmem_we_o), 32'(we));
                        for (int l = 0; l < 4; l++) begin
                            if (dmem_be_o[l] && dmem_we_o) begin
                                chk("store_lane", 32'(dmem_wdata_o[8*l +: 8]), 32'(exp_lane[n_got][l]));
                                bus_mem[(int'(dmem_addr_o[9:0]) + l) % 1024] = dmem_wdata_o[8*l +: 8];
                            end
                        end
                    end else begin
                        chk("extra_request", 32'(n_got + 1), 32'(n_exp));
                    end
                    last_wdata = dmem_wdata_o;
                    rv_wa  = dmem_addr_o;
                    rv_cnt = rdl;
                    n_got++;
                end else begin
                    gcnt--;
                end
            end
        end

        if (c_done == 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_cycle", 32'(c_done), 32'(exp_cyc));
            chk("err", 32'(err_o), 32'(err));
            chk("reg_we", 32'(reg_we_o), 32'(!we && !err));
            chk("rd_addr", 32'(rd_addr_o), 32'(rd));
            chk("n_requests", 32'(n_got), 32'(n_exp));
            last_rdata = rdata_o;
            if (!we && !err) chk("load_data", rdata_o, exp_ld);
            if (we && !err)
                for (int k = 0; k < size; k++) ref_mem[(int'(a[9:0]) + k) % 1024] = wd[8*k +: 8];
            @(negedge clk);
            chk("done_one_cycle", 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, n_req, prev_gnt;
        logic [31:0] ref_w;
        logic [3:0]  r_op;
        logic        r_we;
        logic [31:0] r_a;
        int          sz;

        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end

        // Reset state
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_reg_we", 32'(reg_we_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_dmem_req", 32'(dmem_req_o), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be_o), 32'd0);
        chk("rst_dmem_addr", dmem_addr_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Word store, immediate grant
        do_access(LIS_SW, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3, 0, 0);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);

        // Loads from a known word
        put_word(32'h100, 32'h80FF1234);
        do_access(LIS_LB, 1'b0, 32'h103, 32'h0, 5'd5, 0, 0);
        chk("lb_value", last_rdata, 32'hFFFFFF80);
        do_access(LIS_LBU, 1'b0, 32'h103, 32'h0, 5'd6, 0, 0);
        chk("lbu_value", last_rdata, 32'h00000080);
        do_access(LIS_LH, 1'b0, 32'h102, 32'h0, 5'd0, 0, 1);
        chk("lh_value", last_rdata, 32'hFFFF80FF);

        // Half store with grant withheld for three cycles
        do_access(LIS_SH, 1'b1, 32'h102, 32'h0000ABCD, 5'd1, 3, 0);
`ifndef LSU_MISALIGNED_SPLIT_EN
        chk("sh_wdata_repl", last_wdata, 32'hABCDABCD);
        // Misaligned word load is rejected without a memory request
        do_access(LIS_LW, 1'b0, 32'h101, 32'h0, 5'd7, 0, 0);
`else
        put_word(32'h100, 32'h11223344);
        put_word(32'h104, 32'h55667788);
        do_access(LIS_LW, 1'b0, 32'h103, 32'h0, 5'd7, 0, 0);
        chk("split_lw_value", last_rdata, 32'h66778811);
`endif
        // Illegal op code for the direction
        do_access(LIS_SB, 1'b0, 32'h110, 32'h0, 5'd2, 0, 0);

        // Reset while waiting for the response
        @(negedge clk);
        lis_op_i = LIS_LW; we_i = 1'b0; addr_i = 32'h108; rd_addr_i = 5'd9; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        chk("rstw_req_before", 32'(dmem_req_o), 32'd1);
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        chk("rstw_busy_before", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_busy", 32'(busy_o), 32'd0);
        chk("rstw_req", 32'(dmem_req_o), 32'd0);
        chk("rstw_done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dmem_rvalid_i = 1'b0;
            chk("rstw_late_done", 32'(done_o), 32'd0);
            chk("rstw_late_busy", 32'(busy_o), 32'd0);
        end
        do_access(LIS_LW, 1'b0, 32'h108, 32'h0, 5'd9, 0, 0);

        // req_i held high across RESP: one acceptance per IDLE visit
        ref_w = {ref_mem[16'h107], ref_mem[16'h106], ref_mem[16'h105], ref_mem[16'h104]};
        @(negedge clk);
        lis_op_i = LIS_LW; we_i = 1'b0; addr_i = 32'h104; rd_addr_i = 5'd4; req_i = 1'b1;
        n_done = 0; n_req = 0; prev_gnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 9) req_i = 1'b0;
            dmem_rvalid_i = (prev_gnt != 0);
            dmem_rdata_i  = bus_word(32'h104);
            dmem_gnt_i    = dmem_req_o;
            prev_gnt      = dmem_req_o ? 1 : 0;
            if (dmem_req_o) n_req++;
            if (done_o) begin
                n_done++;
                chk("hold_done_slot", 32'(c % 4), 32'd3);
                chk("hold_rdata", rdata_o, ref_w);
            end
        end
        @(negedge clk);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        chk("hold_done_count", 32'(n_done), 32'd3);
        chk("hold_req_count", 32'(n_req), 32'd3);
        chk("hold_idle_busy", 32'(busy_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r_op = 4'($urandom_range(0, 15));
                r_we = 1'($urandom_range(0, 1));
            end else begin
                r_we = 1'($urandom_range(0, 1));
                r_op = r_we ? 4'(LIS_SB + 4'($urandom_range(0, 2))) : 4'($urandom_range(0, 4));
            end
            sz  = op_bytes(r_op);
            r_a = 32'h100 + 32'($urandom_range(0, 247));
            if ($urandom_range(0, 3) != 0) r_a = r_a & ~(32'(sz) - 32'd1);
            do_access(r_op, r_we, r_a, $urandom, 5'($urandom_range(0, 31)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
